// File: rtl/adder_pkg.sv
// Shared types and op-decoding helpers for the pipelined adder/subtractor.
package adder_pkg;

    typedef enum logic [1:0] {
        ADD  = 2'd0,
        SUB  = 2'd1,
        ADDS = 2'd2,
        SUBS = 2'd3
    } adder_op_t;

    function automatic logic is_sub(input adder_op_t op);
        return (op == SUB) || (op == SUBS);
    endfunction

    function automatic logic is_sat(input adder_op_t op);
        return (op == ADDS) || (op == SUBS);
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SW-bit add with carry-in; also exposes the carry into its MSB
// so the final slice can derive signed overflow.
module adder_slice #(
    parameter int SW = 8
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] s,
    output logic          cout,
    output logic          cmsb
);
    logic [SW:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, cin};
    assign s    = full[SW-1:0];
    assign cout = full[SW];
    // Sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out directly.
    assign cmsb = a[SW-1] ^ b[SW-1] ^ full[SW-1];

endmodule

// File: rtl/pipelined_adder.sv
// Add/sub/saturating adder with the carry chain cut into STAGES registered
// slices; each stage stalls independently under output back-pressure.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_ovf
);
    localparam int SW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    adder_op_t         op_in;
    logic [WIDTH-1:0]  b_in;
    logic [STAGES-1:0] v;
    logic [STAGES-1:0] adv;

    assign op_in = adder_op_t'(in_op);
    assign b_in  = is_sub(op_in) ? ~in_b : in_b;

    assign in_ready = adv[0];

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            // Operand bits still to be consumed on entry to this stage.
            localparam int REM = WIDTH - gi * SW;

            logic [REM-1:0]         a_src;
            logic [REM-1:0]         b_src;
            adder_op_t              op_src;
            logic                   cin_src;
            logic                   v_src;
            logic [(gi+1)*SW-1:0]   sum_cat;
            logic [SW-1:0]          s_slice;
            logic                   cout_slice;
            logic                   cmsb_slice;

            // A stage may load if it is empty or everything after it can move.
            assign adv[gi] = out_ready || !(&v[LAST:gi]);

            adder_slice #(.SW(SW)) u_slice (
                .a    (a_src[SW-1:0]),
                .b    (b_src[SW-1:0]),
                .cin  (cin_src),
                .s    (s_slice),
                .cout (cout_slice),
                .cmsb (cmsb_slice)
            );

            if (gi == 0) begin : g_head
                assign a_src   = in_a;
                assign b_src   = b_in;
                assign op_src  = op_in;
                assign cin_src = is_sub(op_in);
                assign v_src   = in_valid;
                assign sum_cat = s_slice;
            end else begin : g_body
                assign a_src   = g_stage[gi-1].g_mid.a_reg;
                assign b_src   = g_stage[gi-1].g_mid.b_reg;
                assign op_src  = g_stage[gi-1].g_mid.op_reg;
                assign cin_src = g_stage[gi-1].g_mid.carry_reg;
                assign v_src   = g_stage[gi-1].g_mid.v_reg;
                assign sum_cat = {s_slice, g_stage[gi-1].g_mid.sum_reg};
            end

            if (gi < LAST) begin : g_mid
                logic [REM-SW-1:0]    a_reg;
                logic [REM-SW-1:0]    b_reg;
                logic [(gi+1)*SW-1:0] sum_reg;
                adder_op_t            op_reg;
                logic                 carry_reg;
                logic                 v_reg;
                logic                 unused_cmsb;

                assign unused_cmsb = cmsb_slice;

                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        a_reg     <= '0;
                        b_reg     <= '0;
                        sum_reg   <= '0;
                        op_reg    <= ADD;
                        carry_reg <= 1'b0;
                        v_reg     <= 1'b0;
                    end else if (adv[gi]) begin
                        a_reg     <= a_src[REM-1:SW];
                        b_reg     <= b_src[REM-1:SW];
                        sum_reg   <= sum_cat;
                        op_reg    <= op_src;
                        carry_reg <= cout_slice;
                        v_reg     <= v_src;
                    end
                end

                assign v[gi] = v_reg;
            end else begin : g_last
                logic [WIDTH-1:0] sum_next;
                logic             ovf_next;
                logic [WIDTH-1:0] sum_reg;
                logic             carry_reg;
                logic             ovf_reg;
                logic             v_reg;

                always_comb begin
                    ovf_next = cmsb_slice ^ cout_slice;
                    sum_next = sum_cat;
                    if (is_sat(op_src) && ovf_next) begin
                        sum_next = sum_cat[WIDTH-1] ? SAT_MAX : SAT_MIN;
                    end
                end

                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        sum_reg   <= '0;
                        carry_reg <= 1'b0;
                        ovf_reg   <= 1'b0;
                        v_reg     <= 1'b0;
                    end else if (adv[gi]) begin
                        sum_reg   <= sum_next;
                        carry_reg <= cout_slice;
                        ovf_reg   <= ovf_next;
                        v_reg     <= v_src;
                    end
                end

                assign v[gi]     = v_reg;
                assign out_valid = v_reg;
                assign out_sum   = sum_reg;
                assign out_carry = carry_reg;
                assign out_ovf   = ovf_reg;
            end
        end
    endgenerate

endmodule
